// File: rtl/fifo_ser_pkg.sv
// Shared state encoding and sizing helpers for the FIFO word serializer.
package fifo_ser_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int NBYTES     = DEF_DATA_W / DEF_BYTE_W;
  localparam int CNT_W      = $clog2(NBYTES);

  // A one-byte word still needs a one-bit counter.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/fifo_ser_shreg.sv
// Word load/shift register with byte counter.
// Build option FIFO_SER_MSB_FIRST_EN presents the most-significant byte first.
module fifo_ser_shreg
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic [BYTE_W-1:0] cur_byte,
  output logic              last
);

  localparam int NB = DATA_W / BYTE_W;
  localparam int CW = cnt_width(NB);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (shift) begin
`ifdef FIFO_SER_MSB_FIRST_EN
      sreg <= sreg << BYTE_W;
`else
      sreg <= sreg >> BYTE_W;
`endif
      cnt  <= cnt + 1'b1;
    end
  end

`ifdef FIFO_SER_MSB_FIRST_EN
  assign cur_byte = sreg[DATA_W-1 -: BYTE_W];
`else
  assign cur_byte = sreg[BYTE_W-1:0];
`endif
  assign last = (cnt == CW'(NB - 1));

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a registered-output FIFO and streams them as bytes over valid/ready.
// Build option FIFO_SER_MSB_FIRST_EN sends the most-significant byte of each word first.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int LW = 2;

  logic [1:0]    state;
  logic [LW-1:0] lat_cnt;
  logic          fetch_ok;
  logic          lat_done;
  logic          load;
  logic          shift;
  logic          last;

  assign fetch_ok = EN && !fifo_empty;
  assign lat_done = (lat_cnt == LW'(RD_LAT - 1));
  assign load     = (state == WAIT) && lat_done;
  assign shift    = (state == SEND) && out_ready;

  // WAIT covers the FIFO's read latency; data is captured on the edge that ends it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (fetch_ok) state <= REQ;
        REQ: begin
          state   <= WAIT;
          lat_cnt <= '0;
        end
        WAIT: begin
          if (lat_done) state <= SEND;
          else          lat_cnt <= lat_cnt + 1'b1;
        end
        SEND: if (out_ready && last) state <= fetch_ok ? REQ : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_ser_shreg #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_shreg (
    .clk       (Clk),
    .rst       (Rst),
    .load      (load),
    .shift     (shift),
    .load_data (fifo_data),
    .cur_byte  (out_data),
    .last      (last)
  );

  assign fifo_rd   = (state == REQ);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && last;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: FIFO model, directed table, corner sequences, random scoreboard.
module tb_fifo_word_serializer;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int RD_LAT = 1;
  localparam int NB     = DATA_W / BYTE_W;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              EN;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  fifo_word_serializer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .EN         (EN),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // FIFO model with registered read data delayed RD_LAT cycles
  logic [DATA_W-1:0] mem [0:1023];
  int                wr_ptr = 0;
  int                rd_ptr = 0;
  logic [DATA_W-1:0] dl [RD_LAT];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = dl[RD_LAT-1];

  always @(posedge Clk) begin
    if (fifo_rd && !fifo_empty) begin
      dl[0]  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
    for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
  end

  // Sample log taken away from the active edge
  typedef struct {
    logic v, r, l, rd, emp, bsy, rst;
    logic [BYTE_W-1:0] d;
    int cyc;
  } smp_t;
  smp_t smp[$];
  int   cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk)
    smp.push_back('{out_valid, out_ready, out_last, fifo_rd, fifo_empty, busy, Rst, out_data, cyc});

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Reference byte order: byte i of a word in emission order
  function automatic logic [BYTE_W-1:0] exp_byte(input logic [DATA_W-1:0] w, input int i);
`ifdef FIFO_SER_MSB_FIRST_EN
    return BYTE_W'(w >> (BYTE_W * (NB - 1 - i)));
`else
    return BYTE_W'(w >> (BYTE_W * i));
`endif
  endfunction

  function automatic int hs_count(input int s0);
    int n = 0;
    for (int j = s0; j < smp.size(); j++) if (smp[j].v && smp[j].r && !smp[j].rst) n++;
    return n;
  endfunction

  function automatic int rd_count(input int s0);
    int n = 0;
    for (int j = s0; j < smp.size(); j++) if (smp[j].rd) n++;
    return n;
  endfunction

  logic [BYTE_W-1:0] hs_d[$];
  logic              hs_l[$];
  int                hs_c[$];

  task automatic collect(input int s0, input int s1);
    hs_d.delete(); hs_l.delete(); hs_c.delete();
    for (int j = s0; j < s1; j++)
      if (smp[j].v && smp[j].r && !smp[j].rst) begin
        hs_d.push_back(smp[j].d);
        hs_l.push_back(smp[j].l);
        hs_c.push_back(smp[j].cyc);
      end
  endtask

  task automatic wait_done(input int s0, input int nb, input int budget, input string name);
    int k = 0;
    while (!(hs_count(s0) >= nb && !busy) && k < budget) begin
      tick();
      k++;
    end
    chk({name, " completes in budget"}, 64'(k < budget), 64'd1);
  endtask

  // Compare every handshaken byte since s0 with the words popped since w0
  task automatic check_stream(input int s0, input int w0, input string name);
    int nw, s1, uf;
    nw = rd_ptr - w0;
    s1 = smp.size();
    collect(s0, s1);
    chk({name, " byte count"}, hs_d.size(), nw * NB);
    for (int b = 0; b < hs_d.size() && b < nw * NB; b++) begin
      chk({name, " data"}, hs_d[b], exp_byte(mem[w0 + b / NB], b % NB));
      chk({name, " last"}, hs_l[b], 64'((b % NB) == NB - 1));
    end
    for (int j = s0; j < s1 - 1; j++)
      if (smp[j].v && !smp[j].r && !smp[j].rst && !smp[j+1].rst)
        chk({name, " stall hold"}, {smp[j+1].v, smp[j+1].l, smp[j+1].d},
            {1'b1, smp[j].l, smp[j].d});
    uf = 0;
    for (int j = s0; j < s1; j++) if (smp[j].rd && smp[j].emp) uf++;
    chk({name, " no underflow"}, uf, 0);
  endtask

  typedef struct {
    logic [DATA_W-1:0] word;
    logic [7:0]        pat;
    logic [DATA_W-1:0] seq_lsb;
    logic [DATA_W-1:0] seq_msb;
  } vec_t;
  vec_t vt[7];

  initial begin
    int s0, s1, w0, w1, bad;
    logic [DATA_W-1:0] seq, wa, wb;
    logic [7:0] pat;

    vt[0] = '{32'h44332211, 8'hFF, 32'h11223344, 32'h44332211};
    vt[1] = '{32'h44332211, 8'h99, 32'h11223344, 32'h44332211};
    vt[2] = '{32'hA5A50FF0, 8'h55, 32'hF00FA5A5, 32'hA5A50FF0};
    vt[3] = '{32'hDEADBEEF, 8'h0F, 32'hEFBEADDE, 32'hDEADBEEF};
    vt[4] = '{32'h00000000, 8'hFF, 32'h00000000, 32'h00000000};
    vt[5] = '{32'hFFFFFFFF, 8'hFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[6] = '{32'h80000001, 8'h3C, 32'h01000080, 32'h80000001};

    Rst = 1'b1; EN = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("reset fifo_rd", fifo_rd, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_last", out_last, 0);
    chk("reset busy", busy, 0);
    @(negedge Clk) Rst = 1'b0;
    tick();

    // Directed table: one word each with a per-cycle ready pattern
    EN = 1'b1;
    for (int t = 0; t < 7; t++) begin
      s0 = smp.size();
      w0 = rd_ptr;
      pat = vt[t].pat;
`ifdef FIFO_SER_MSB_FIRST_EN
      seq = vt[t].seq_msb;
`else
      seq = vt[t].seq_lsb;
`endif
      push(vt[t].word);
      bad = 1;
      for (int k = 0; k < 100; k++) begin
        tick();
        out_ready = pat[k % 8];
        if (hs_count(s0) >= NB && !busy) begin
          bad = 0;
          break;
        end
      end
      chk("table completes", bad, 0);
      chk("table busy low", busy, 0);
      chk("table one rd pulse", rd_count(s0), 1);
      collect(s0, smp.size());
      chk("table byte count", hs_d.size(), NB);
      for (int b = 0; b < NB && b < hs_d.size(); b++) begin
        chk("table byte", hs_d[b], BYTE_W'(seq >> (BYTE_W * (NB - 1 - b))));
        chk("table last", hs_l[b], 64'(b == NB - 1));
        if (pat == 8'hFF && b > 0) chk("table back-to-back", hs_c[b] - hs_c[b-1], 1);
      end
      check_stream(s0, w0, "table");
    end

    // Five words back to back: 2 + RD_LAT cycle spacing across word boundaries
    s0 = smp.size(); w0 = rd_ptr;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) push(DATA_W'(j));
    wait_done(s0, 5 * NB, 200, "burst");
    chk("burst rd pulses", rd_count(s0), 5);
    collect(s0, smp.size());
    chk("burst count", hs_d.size(), 5 * NB);
    for (int b = 0; b < hs_d.size() && b < 5 * NB; b++) begin
      chk("burst data", hs_d[b], exp_byte(DATA_W'(b / NB), b % NB));
      if (b > 0) chk("burst spacing", hs_c[b] - hs_c[b-1], (b % NB == 0) ? 2 + RD_LAT : 1);
    end

    // Empty FIFO with EN high: nothing moves
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (fifo_rd || out_valid || busy) bad++;
    end
    chk("empty idle cycles", bad, 0);

    // EN dropped during the second byte
    s0 = smp.size();
    wa = 32'h0A0B0C0D; wb = 32'h01020304;
    push(wa); push(wb);
    bad = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (hs_count(s0) >= 1) begin
        bad = 0;
        break;
      end
    end
    EN = 1'b0;
    chk("en-drop reach byte 2", bad, 0);
    wait_done(s0, NB, 50, "en-drop first word");
    repeat (10) tick();
    chk("en-drop rd pulses", rd_count(s0), 1);
    chk("en-drop word left", wr_ptr - rd_ptr, 1);
    chk("en-drop idle", busy, 0);
    collect(s0, smp.size());
    chk("en-drop count", hs_d.size(), NB);
    for (int b = 0; b < NB && b < hs_d.size(); b++) chk("en-drop data", hs_d[b], exp_byte(wa, b));
    s1 = smp.size();
    EN = 1'b1;
    wait_done(s1, NB, 50, "en-resume");
    chk("en-resume rd pulses", rd_count(s1), 1);
    collect(s1, smp.size());
    chk("en-resume count", hs_d.size(), NB);
    for (int b = 0; b < NB && b < hs_d.size(); b++) chk("en-resume data", hs_d[b], exp_byte(wb, b));

    // Reset pulsed during the third byte
    s0 = smp.size();
    wa = 32'h44332211; wb = 32'hDDCCBBAA;
    push(wa); push(wb);
    bad = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (hs_count(s0) >= 2) begin
        bad = 0;
        break;
      end
    end
    chk("reset-mid reach byte 3", bad, 0);
    #2 Rst = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset out_data", out_data, 0);
    chk("async reset out_last", out_last, 0);
    chk("async reset fifo_rd", fifo_rd, 0);
    chk("async reset busy", busy, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    s1 = smp.size();
    w1 = rd_ptr;
    collect(s0, s1);
    chk("reset-mid pre count", hs_d.size(), 2);
    for (int b = 0; b < 2 && b < hs_d.size(); b++) chk("reset-mid pre data", hs_d[b], exp_byte(wa, b));
    wait_done(s1, NB, 50, "reset-mid restart");
    chk("reset-mid fifo drained", wr_ptr - rd_ptr, 0);
    collect(s1, smp.size());
    chk("reset-mid post count", hs_d.size(), NB);
    for (int b = 0; b < NB && b < hs_d.size(); b++) chk("reset-mid post data", hs_d[b], exp_byte(wb, b));
    check_stream(s1, w1, "reset-mid");

    // Random traffic against the scoreboard
    s0 = smp.size(); w0 = rd_ptr;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0 && (wr_ptr - rd_ptr) < 8 && wr_ptr < 1000) push($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      EN = ($urandom_range(0, 9) != 0);
    end
    EN = 1'b1; out_ready = 1'b1;
    bad = 1;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (fifo_empty && !busy) begin
        bad = 0;
        break;
      end
    end
    chk("random drain", bad, 0);
    check_stream(s0, w0, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
